uivbuf_wr_ctrl: RTL and testbench

// Write-side frame-buffer index manager for the multi-buffer VDMA ring. Picks the buffer each

---
 rtl/uivbuf_wr_ctrl_if.sv | 29 ++
 rtl/uivbuf_wr_ctrl.sv | 149 ++++++++++++++
 tb/tb_uivbuf_wr_ctrl.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/uivbuf_wr_ctrl_if.sv
// Handshake/status bundle between the write-side frame-buffer index manager
// and its surroundings (frame sync, write DMA, reader index, status).
interface uivbuf_wr_ctrl_if #(
   parameter int FCNT_W = 16
);
   logic              en_i;
   logic              vs_i;
   logic              fdone_i;
   logic [7:0]        rd_bufn_i;
   logic [7:0]        bufn_o;
   logic              fstart_o;
   logic [7:0]        cmt_bufn_o;
   logic              cmt_vld_o;
   logic              busy_o;
   logic              drop_o;
   logic [FCNT_W-1:0] fcnt_o;

   // Environment side: drives frame sync, DMA completion and reader index.
   modport master (
      output en_i, vs_i, fdone_i, rd_bufn_i,
      input  bufn_o, fstart_o, cmt_bufn_o, cmt_vld_o, busy_o, drop_o, fcnt_o
   );

   // Controller side.
   modport slave (
      input  en_i, vs_i, fdone_i, rd_bufn_i,
      output bufn_o, fstart_o, cmt_bufn_o, cmt_vld_o, busy_o, drop_o, fcnt_o
   );
endinterface

// File: rtl/uivbuf_wr_ctrl.sv
// Write-side frame-buffer index manager for the multi-buffer VDMA ring.
// Chooses the buffer each incoming frame is written into, never the one the
// reader holds, and publishes the last fully written buffer to the reader.
//
// state      | meaning
// -----------+---------------------------------------------------------
// ST_IDLE    | capture disabled; waits for en_i
// ST_WAIT_VS | armed; next vs_i selects a target and starts the DMA
// ST_WRITE   | DMA writing bufn_o; fdone_i commits, lone vs_i is an overrun
module uivbuf_wr_ctrl #(
   parameter int BUF_LENTH = 3,
   parameter int FCNT_W    = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   uivbuf_wr_ctrl_if.slave   bus
);

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_WAIT_VS = 2'd1,
      ST_WRITE   = 2'd2
   } state_t;

   localparam logic [7:0]        LAST_IDX = 8'(BUF_LENTH - 1);
   localparam logic [FCNT_W-1:0] FCNT_ONE = {{(FCNT_W-1){1'b0}}, 1'b1};

   state_t            state_q, state_d;
   logic              first_q, first_d;
   logic [7:0]        bufn_q, bufn_d;
   logic [7:0]        cmt_bufn_q, cmt_bufn_d;
   logic              cmt_vld_q, cmt_vld_d;
   logic              fstart_q, fstart_d;
   logic              drop_q, drop_d;
   logic              busy_q, busy_d;
   logic [FCNT_W-1:0] fcnt_q, fcnt_d;

   // Ring successor; the >= keeps the result in range even for a stray index.
   function automatic logic [7:0] inc_idx(input logic [7:0] idx);
      if (idx >= LAST_IDX) begin
         return 8'd0;
      end
      return idx + 8'd1;
   endfunction

   // Next write target: the very first frame reuses the reset index, later
   // frames advance; a single skip steps over the buffer the reader holds.
   function automatic logic [7:0] pick_target(input logic [7:0] base,
                                              input logic       first,
                                              input logic [7:0] rd_bufn);
      logic [7:0] cand;
      cand = first ? base : inc_idx(base);
      if ((BUF_LENTH > 1) && (cand == rd_bufn)) begin
         cand = inc_idx(cand);
      end
      return cand;
   endfunction

   // State and datapath registers with synchronous reset.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= ST_IDLE;
         first_q    <= 1'b1;
         bufn_q     <= 8'd0;
         cmt_bufn_q <= 8'd0;
         cmt_vld_q  <= 1'b0;
         fstart_q   <= 1'b0;
         drop_q     <= 1'b0;
         busy_q     <= 1'b0;
         fcnt_q     <= '0;
      end else begin
         state_q    <= state_d;
         first_q    <= first_d;
         bufn_q     <= bufn_d;
         cmt_bufn_q <= cmt_bufn_d;
         cmt_vld_q  <= cmt_vld_d;
         fstart_q   <= fstart_d;
         drop_q     <= drop_d;
         busy_q     <= busy_d;
         fcnt_q     <= fcnt_d;
      end
   end

   // Next-state decode; WRITE only leaves on a plain fdone_i, never on en_i.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.en_i) state_d = ST_WAIT_VS;
         end
         ST_WAIT_VS: begin
            if (!bus.en_i)     state_d = ST_IDLE;
            else if (bus.vs_i) state_d = ST_WRITE;
         end
         ST_WRITE: begin
            if (bus.fdone_i && !bus.vs_i) state_d = ST_WAIT_VS;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Output and index datapath: target select, commit, overrun restart.
   always_comb begin
      first_d    = first_q;
      bufn_d     = bufn_q;
      cmt_bufn_d = cmt_bufn_q;
      cmt_vld_d  = cmt_vld_q;
      fcnt_d     = fcnt_q;
      fstart_d   = 1'b0;
      drop_d     = 1'b0;
      busy_d     = (state_d == ST_WRITE);
      unique case (state_q)
         ST_WAIT_VS: begin
            if (bus.en_i && bus.vs_i) begin
               bufn_d   = pick_target(bufn_q, first_q, bus.rd_bufn_i);
               fstart_d = 1'b1;
            end
         end
         ST_WRITE: begin
            if (bus.fdone_i) begin
               cmt_bufn_d = bufn_q;
               cmt_vld_d  = 1'b1;
               fcnt_d     = fcnt_q + FCNT_ONE;
               first_d    = 1'b0;
               // Back-to-back frame: advance from the buffer just committed.
               if (bus.vs_i) begin
                  bufn_d   = pick_target(bufn_q, 1'b0, bus.rd_bufn_i);
                  fstart_d = 1'b1;
               end
            end else if (bus.vs_i) begin
               // Overrun: abandon the partial frame and restart in place.
               drop_d   = 1'b1;
               fstart_d = 1'b1;
            end
         end
         default: begin
         end
      endcase
   end

   assign bus.bufn_o     = bufn_q;
   assign bus.fstart_o   = fstart_q;
   assign bus.cmt_bufn_o = cmt_bufn_q;
   assign bus.cmt_vld_o  = cmt_vld_q;
   assign bus.busy_o     = busy_q;
   assign bus.drop_o     = drop_q;
   assign bus.fcnt_o     = fcnt_q;

endmodule

// File: tb/tb_uivbuf_wr_ctrl.sv
// Bench for uivbuf_wr_ctrl: a frame-level reference model checked against the
// DUT every cycle, plus hand-computed expectations for each directed scenario.
module tb_uivbuf_wr_ctrl;

   localparam int L  = 3;
   localparam int FW = 16;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   uivbuf_wr_ctrl_if #(.FCNT_W(FW)) bus ();

   uivbuf_wr_ctrl #(.BUF_LENTH(L), .FCNT_W(FW)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   int checks   = 0;
   int failures = 0;
   int drop_seen = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: frame-level view, indices as plain modular integers.
   typedef enum int {M_OFF, M_ARMED, M_WRITING} mmode_t;
   mmode_t m_mode   = M_OFF;
   bit     m_valid  = 1'b0;
   bit     m_first  = 1'b1;
   int     m_bufn   = 0;
   int     m_cmt    = 0;
   bit     m_vld    = 1'b0;
   int     m_fcnt   = 0;
   bit     m_fstart = 1'b0;
   bit     m_drop   = 1'b0;

   function automatic int avoid_reader(input int c, input int rd);
      if (L > 1 && c == rd) return (c + 1) % L;
      return c;
   endfunction

   always @(posedge clk) begin
      m_fstart = 1'b0;
      m_drop   = 1'b0;
      if (rst) begin
         m_valid = 1'b1;
         m_mode  = M_OFF;
         m_first = 1'b1;
         m_bufn  = 0;
         m_cmt   = 0;
         m_vld   = 1'b0;
         m_fcnt  = 0;
      end else begin
         case (m_mode)
            M_OFF: if (bus.en_i) m_mode = M_ARMED;
            M_ARMED: begin
               if (!bus.en_i) m_mode = M_OFF;
               else if (bus.vs_i) begin
                  m_bufn   = avoid_reader(m_first ? m_bufn : (m_bufn + 1) % L, int'(bus.rd_bufn_i));
                  m_fstart = 1'b1;
                  m_mode   = M_WRITING;
               end
            end
            M_WRITING: begin
               if (bus.fdone_i) begin
                  m_cmt   = m_bufn;
                  m_vld   = 1'b1;
                  m_fcnt  = (m_fcnt + 1) % (1 << FW);
                  m_first = 1'b0;
                  if (bus.vs_i) begin
                     m_bufn   = avoid_reader((m_bufn + 1) % L, int'(bus.rd_bufn_i));
                     m_fstart = 1'b1;
                  end else begin
                     m_mode = M_ARMED;
                  end
               end else if (bus.vs_i) begin
                  m_drop   = 1'b1;
                  m_fstart = 1'b1;
               end
            end
            default: m_mode = M_OFF;
         endcase
      end
   end

   // Every-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (m_valid) begin
         chk("bufn_o",     32'(bus.bufn_o),     32'(m_bufn));
         chk("fstart_o",   32'(bus.fstart_o),   32'(m_fstart));
         chk("cmt_bufn_o", 32'(bus.cmt_bufn_o), 32'(m_cmt));
         chk("cmt_vld_o",  32'(bus.cmt_vld_o),  32'(m_vld));
         chk("busy_o",     32'(bus.busy_o),     32'(m_mode == M_WRITING));
         chk("drop_o",     32'(bus.drop_o),     32'(m_drop));
         chk("fcnt_o",     32'(bus.fcnt_o),     32'(m_fcnt));
         if (bus.drop_o === 1'b1) drop_seen++;
      end
   end

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic pulse_vs();
      bus.vs_i = 1'b1;
      tick(1);
      bus.vs_i = 1'b0;
   endtask

   task automatic pulse_fdone();
      bus.fdone_i = 1'b1;
      tick(1);
      bus.fdone_i = 1'b0;
   endtask

   initial begin
      int exp_ring [4];
      exp_ring = '{0, 1, 2, 0};
      bus.en_i      = 1'b0;
      bus.vs_i      = 1'b0;
      bus.fdone_i   = 1'b0;
      bus.rd_bufn_i = 8'hFF;
      rst = 1'b1;
      tick(2);
      chk("reset bufn_o", 32'(bus.bufn_o), 32'd0);
      chk("reset busy_o", 32'(bus.busy_o), 32'd0);
      rst = 1'b0;

      // T1 ring wrap
      bus.en_i = 1'b1;
      tick(2);
      for (int i = 0; i < 4; i++) begin
         pulse_vs();
         chk("T1 fstart", 32'(bus.fstart_o), 32'd1);
         chk("T1 bufn",   32'(bus.bufn_o),   32'(exp_ring[i]));
         tick(100);
         pulse_fdone();
         chk("T1 cmt_bufn", 32'(bus.cmt_bufn_o), 32'(exp_ring[i]));
         tick(1);
      end
      chk("T1 fcnt",      32'(bus.fcnt_o), 32'd4);
      chk("T1 no drop",   32'(drop_seen),  32'd0);

      // T2 skip the reader's buffer (last commit = 0, reader on 1)
      bus.rd_bufn_i = 8'd1;
      pulse_vs();
      chk("T2 fstart", 32'(bus.fstart_o), 32'd1);
      chk("T2 bufn",   32'(bus.bufn_o),   32'd2);
      tick(3);
      pulse_fdone();
      bus.rd_bufn_i = 8'hFF;
      chk("T2 cmt_bufn", 32'(bus.cmt_bufn_o), 32'd2);
      tick(2);

      // T3 overrun restarts in the same buffer
      pulse_vs();
      chk("T3 bufn first", 32'(bus.bufn_o), 32'd0);
      tick(5);
      pulse_vs();
      chk("T3 drop",   32'(bus.drop_o),   32'd1);
      chk("T3 fstart", 32'(bus.fstart_o), 32'd1);
      chk("T3 bufn",   32'(bus.bufn_o),   32'd0);
      chk("T3 fcnt",   32'(bus.fcnt_o),   32'd5);
      tick(1);
      chk("T3 drop one cycle", 32'(bus.drop_o), 32'd0);
      chk("T3 drop count",     32'(drop_seen),  32'd1);
      pulse_fdone();
      chk("T3 fcnt after", 32'(bus.fcnt_o), 32'd6);
      tick(2);

      // T4 simultaneous vs/fdone while writing buffer 1
      pulse_vs();
      chk("T4 bufn start", 32'(bus.bufn_o), 32'd1);
      tick(3);
      bus.vs_i    = 1'b1;
      bus.fdone_i = 1'b1;
      tick(1);
      bus.vs_i    = 1'b0;
      bus.fdone_i = 1'b0;
      chk("T4 cmt_bufn", 32'(bus.cmt_bufn_o), 32'd1);
      chk("T4 fcnt",     32'(bus.fcnt_o),     32'd7);
      chk("T4 bufn",     32'(bus.bufn_o),     32'd2);
      chk("T4 fstart",   32'(bus.fstart_o),   32'd1);
      chk("T4 busy",     32'(bus.busy_o),     32'd1);
      tick(2);
      pulse_fdone();
      chk("T4 fcnt end", 32'(bus.fcnt_o), 32'd8);
      tick(2);

      // T5 reset in the middle of a write
      pulse_vs();
      chk("T5 busy", 32'(bus.busy_o), 32'd1);
      tick(2);
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      chk("T5 bufn",   32'(bus.bufn_o),     32'd0);
      chk("T5 cmt",    32'(bus.cmt_bufn_o), 32'd0);
      chk("T5 vld",    32'(bus.cmt_vld_o),  32'd0);
      chk("T5 fcnt",   32'(bus.fcnt_o),     32'd0);
      chk("T5 busy0",  32'(bus.busy_o),     32'd0);
      chk("T5 fstart", 32'(bus.fstart_o),   32'd0);
      tick(1);
      pulse_fdone();
      tick(1);
      chk("T5 fcnt stays", 32'(bus.fcnt_o),    32'd0);
      chk("T5 vld stays",  32'(bus.cmt_vld_o), 32'd0);

      // T6 enable gating
      bus.en_i = 1'b0;
      tick(2);
      pulse_vs();
      chk("T6 no fstart", 32'(bus.fstart_o), 32'd0);
      tick(2);
      bus.en_i = 1'b1;
      tick(2);
      pulse_vs();
      chk("T6 fstart", 32'(bus.fstart_o), 32'd1);
      chk("T6 bufn",   32'(bus.bufn_o),   32'd0);
      tick(3);
      pulse_fdone();
      chk("T6 fcnt", 32'(bus.fcnt_o), 32'd1);
      tick(3);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
